// File: rtl/ticket_vendor_param_if.sv
// Bill-acceptor / actuator bundle for ticket_vendor_param.
// master = bill front end, slave = the vendor.
interface ticket_vendor_param_if #(
  parameter int unsigned CREDIT_W = 6
);
  logic                ten;
  logic                twenty;
  logic                cancel;
  logic                ready;
  logic                bill;
  logic                dispense;
  logic                return_sig;
  logic                reject;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output ten, twenty, cancel,
    input  ready, bill, dispense, return_sig, reject, credit
  );

  modport slave (
    input  ten, twenty, cancel,
    output ready, bill, dispense, return_sig, reject, credit
  );
endinterface

// File: rtl/ticket_vendor_param.sv
// Parametrised ticket vendor: 10/20-unit bills toward PRICE steps, dispense, change and refund.
// Optional macro TICKET_VENDOR_STATS_EN adds saturating tickets_sold / refunds counters.
module ticket_vendor_param #(
  parameter int unsigned PRICE    = 4,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                  clk,
  input  logic                  clear_n,
  ticket_vendor_param_if.slave  bus
`ifdef TICKET_VENDOR_STATS_EN
  ,
  output logic [15:0]           tickets_sold,
  output logic [15:0]           refunds
`endif
);

  typedef enum logic [1:0] {
    S_RDY  = 2'd0,
    S_BILL = 2'd1,
    S_DISP = 2'd2,
    S_RTN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_reject;
  logic                w_reject_nxt;
  logic                w_bill_in;
  logic [CREDIT_W:0]   w_steps;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W:0]   w_price;

  assign w_price = (CREDIT_W+1)'(PRICE);

  // ten wins over a simultaneous twenty
  always_comb begin
    w_bill_in = bus.ten | bus.twenty;
    w_steps   = '0;
    if (bus.ten)
      w_steps = (CREDIT_W+1)'(1);
    else if (bus.twenty)
      w_steps = (CREDIT_W+1)'(2);
    w_sum = {1'b0, r_credit} + w_steps;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_reject_nxt = 1'b0;
    case (r_state)
      S_RDY, S_BILL: begin
        if ((r_state == S_BILL) && bus.cancel) begin
          w_state_nxt  = S_RTN;
          w_reject_nxt = w_bill_in;
        end else if (w_bill_in) begin
          if (w_sum >= w_price) begin
            // change is computed on the same edge that enters DISP
            w_state_nxt  = S_DISP;
            w_credit_nxt = CREDIT_W'(w_sum - w_price);
          end else begin
            w_state_nxt  = S_BILL;
            w_credit_nxt = CREDIT_W'(w_sum);
          end
        end
      end
      S_DISP: begin
        w_reject_nxt = w_bill_in;
        w_state_nxt  = (r_credit != '0) ? S_RTN : S_RDY;
      end
      S_RTN: begin
        w_reject_nxt = w_bill_in;
        if (r_credit <= CREDIT_W'(1)) begin
          w_state_nxt  = S_RDY;
          w_credit_nxt = '0;
        end else begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = S_RDY;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_RDY;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  assign bus.ready      = (r_state == S_RDY);
  assign bus.bill       = (r_state == S_BILL);
  assign bus.dispense   = (r_state == S_DISP);
  assign bus.return_sig = (r_state == S_RTN);
  assign bus.reject     = r_reject;
  assign bus.credit     = r_credit;

`ifdef TICKET_VENDOR_STATS_EN
  logic [15:0] r_tickets_sold;
  logic [15:0] r_refunds;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_tickets_sold <= '0;
      r_refunds      <= '0;
    end else begin
      if ((r_state == S_DISP) && (r_tickets_sold != '1))
        r_tickets_sold <= r_tickets_sold + 16'd1;
      if ((r_state == S_BILL) && bus.cancel && (r_refunds != '1))
        r_refunds <= r_refunds + 16'd1;
    end
  end

  assign tickets_sold = r_tickets_sold;
  assign refunds      = r_refunds;
`endif

endmodule

// File: doc/ticket_vendor_param.md
Name: ticket_vendor_param

Overview:
- Parametrised successor to the fixed-price ticket machine FSM.
- Takes 10- and 20-unit bills toward a configurable ticket price and dispenses a ticket once credit reaches the price.
- Returns any overpayment one unit per cycle, and refunds all credit on cancel.
- Sits between the bill-acceptor front end (single-cycle bill pulses) and the dispenser/coin-return actuators.

Parameters:
- PRICE, 4, ticket price in 10-unit steps; legal range 1..60.
- CREDIT_W, 6, credit register width; must satisfy 2^CREDIT_W > PRICE+1.

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- ten  input  1  one-cycle pulse: 10-unit bill inserted (1 step)
- twenty  input  1  one-cycle pulse: 20-unit bill inserted (2 steps)
- cancel  input  1  one-cycle pulse: customer requests refund
- ready  output  1  high in RDY state
- bill  output  1  high in BILL state
- dispense  output  1  one-cycle ticket-release pulse (DISP state)
- return_sig  output  1  high each cycle one 10-unit step is returned (RTN state)
- reject  output  1  registered one-cycle pulse: bill arrived while busy and was not credited
- credit  output  CREDIT_W  current credit / pending change, in steps

Behaviour:
- Reset (clear_n low, async):
  - state=RDY, credit=0, ready=1.
  - bill, dispense, return_sig and reject are all 0.
  - Reset release is synchronous to clk.
- Moore outputs: ready, bill, dispense and return_sig decode from the state register only.
- Bill priority: if ten and twenty are high in the same cycle, only ten is credited. twenty is dropped silently; no reject.
- States and transitions:
  - RDY:
    - cancel is ignored.
    - Bill: credit += 1 or 2. If the new credit >= PRICE, go to DISP; otherwise go to BILL.
  - BILL:
    - cancel takes priority over a same-cycle bill. Go to RTN with credit unchanged; the bill is rejected (reject=1 next cycle).
    - Bill: credit += 1 or 2. If the new credit >= PRICE, go to DISP; otherwise stay in BILL.
  - DISP:
    - Lasts exactly 1 cycle; dispense=1.
    - On entry, credit already holds new_credit - PRICE (0 or 1). The subtraction happens in the same clock edge that enters DISP.
    - Next state: RTN if credit>0, else RDY.
  - RTN:
    - return_sig=1 every cycle. credit decrements by 1 each cycle.
    - When credit reaches 0 after the decrement, go to RDY.
    - Return count therefore equals credit at RTN entry.
- Busy states (DISP, RTN): ten/twenty raise reject the next cycle; credit is unchanged. cancel is ignored.
- Latency:
  - A bill completing the price gives dispense high 1 cycle after the sampling edge.
  - The first return_sig follows the dispense cycle, one per cycle after that.
- Width and range:
  - Credit never exceeds PRICE+1, so no overflow.
  - With PRICE=1, a twenty from RDY dispenses and then returns 1.
- Unreachable state encodings recover to RDY with credit=0.
- Reset mid-operation (any state, including RTN) aborts immediately. Outstanding credit is lost; no further pulses.

Optional Feature:
- Macro: TICKET_VENDOR_STATS_EN.
- When defined:
  - Adds output tickets_sold [15:0]: increments on every DISP cycle and saturates at 16'hFFFF.
  - Adds output refunds [15:0]: increments on every cancel accepted in BILL and saturates.
  - Both counters reset to 0 via clear_n.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- PRICE=4, ten on 4 separate cycles -> bill high after 1st; dispense=1 exactly once in the cycle after the 4th; no return_sig; then ready=1, credit=0.
- PRICE=4, twenty, twenty -> dispense after 2nd; credit=0; back to RDY next cycle.
- PRICE=4, ten, ten, ten, twenty (credit 5) -> DISP with credit=1; then one return_sig cycle; then RDY.
- PRICE=4, ten, twenty, then cancel together with ten -> ten rejected (reject=1 one cycle); 3 consecutive return_sig cycles (credit 3,2,1 -> 0); then RDY; no dispense.
- During DISP and RTN, pulse twenty and cancel -> reject pulses for twenty; cancel ignored; return count unchanged; ten+twenty together in BILL credits only 1.
- clear_n low during 2nd return_sig cycle of a 3-unit refund -> outputs go to reset values asynchronously; ready=1 after release; with TICKET_VENDOR_STATS_EN, counters read 0.
